// File: rtl/choice_pkg.sv
// Shared types, default parameters and counter-update helper for the choice predictor.
package choice_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } choice_state_e;

    localparam int unsigned DEF_HIST_BITS = 12;
    localparam int unsigned DEF_CTR_BITS  = 2;
    localparam int unsigned MAX_CTR_BITS  = 4;

    // Saturating choice-counter update; ctr_bits selects the live width (2..4).
    function automatic logic [MAX_CTR_BITS-1:0] sat_next(
        input logic [MAX_CTR_BITS-1:0] ctr,
        input logic                    local_correct,
        input logic                    global_correct,
        input int unsigned             ctr_bits = DEF_CTR_BITS
    );
        logic [MAX_CTR_BITS-1:0] ctr_max;
        ctr_max = MAX_CTR_BITS'((32'd1 << ctr_bits) - 32'd1);
        if (global_correct && !local_correct) begin
            return (ctr >= ctr_max) ? ctr_max : ctr + MAX_CTR_BITS'(1);
        end else if (local_correct && !global_correct) begin
            return (ctr == '0) ? '0 : ctr - MAX_CTR_BITS'(1);
        end
        return ctr;
    endfunction

endpackage

// File: rtl/choice_counter_table.sv
// Counter storage: one write port, two asynchronous read ports (lookup and training).
module choice_counter_table
    import choice_pkg::*;
#(
    parameter int unsigned HIST_BITS = DEF_HIST_BITS,
    parameter int unsigned CTR_BITS  = DEF_CTR_BITS
) (
    input  logic                 clock,
    input  logic                 i_wr_en,
    input  logic [HIST_BITS-1:0] i_wr_idx,
    input  logic [CTR_BITS-1:0]  i_wr_data,
    input  logic [HIST_BITS-1:0] i_rd_idx,
    output logic [CTR_BITS-1:0]  o_rd_data_c,
    input  logic [HIST_BITS-1:0] i_upd_idx,
    output logic [CTR_BITS-1:0]  o_upd_data_c
);

    localparam int unsigned DEPTH = 2 ** HIST_BITS;

    logic [CTR_BITS-1:0] r_mem [DEPTH];

    // No reset: contents are defined only by the INIT sweep.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data_c  = r_mem[i_rd_idx];
    assign o_upd_data_c = r_mem[i_upd_idx];

endmodule

// File: rtl/choice_predictor_table.sv
// Tournament choice predictor: GHR-indexed saturating counters choosing local vs global.
// Optional macro CHOICE_BYPASS_EN forwards a same-cycle training result to a colliding lookup.
module choice_predictor_table
    import choice_pkg::*;
#(
    parameter int unsigned HIST_BITS = DEF_HIST_BITS,
    parameter int unsigned CTR_BITS  = DEF_CTR_BITS,
    parameter int unsigned RESET_CTR = 2 ** (CTR_BITS - 1) - 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lookup_valid,
    output logic                 pred_valid,
    output logic                 prediction,
    output logic [HIST_BITS-1:0] lookup_hist,
    input  logic                 update_valid,
    input  logic [HIST_BITS-1:0] update_hist,
    input  logic                 update_taken,
    input  logic                 local_correct,
    input  logic                 global_correct,
    output logic                 ready
);

    choice_state_e        r_state;
    choice_state_e        w_state_next;
    logic [HIST_BITS-1:0] r_init_ptr;
    logic [HIST_BITS-1:0] w_init_ptr_next;
    logic [HIST_BITS-1:0] r_ghr;

    logic                 r_pred_valid;
    logic                 r_prediction;
    logic [HIST_BITS-1:0] r_lookup_hist;
    logic                 r_ready;

    logic                 w_lookup_en;
    logic                 w_upd_en;
    logic                 w_tbl_we;
    logic [HIST_BITS-1:0] w_tbl_widx;
    logic [CTR_BITS-1:0]  w_tbl_wdata;
    logic [CTR_BITS-1:0]  w_rd_ctr;
    logic [CTR_BITS-1:0]  w_upd_ctr;
    logic [CTR_BITS-1:0]  w_train_next;
    logic [CTR_BITS-1:0]  w_lookup_ctr;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_ptr <= w_init_ptr_next;
        end
    end

    // Next state: sweep every index once, then stay in READY until reset
    always_comb begin
        w_state_next    = r_state;
        w_init_ptr_next = r_init_ptr;
        case (r_state)
            INIT: begin
                w_init_ptr_next = r_init_ptr + HIST_BITS'(1);
                if (&r_init_ptr) begin
                    w_state_next = READY;
                end
            end
            READY:   w_state_next = READY;
            default: w_state_next = INIT;
        endcase
    end

    assign w_lookup_en  = (r_state == READY) && lookup_valid;
    assign w_upd_en     = (r_state == READY) && update_valid;
    assign w_train_next = CTR_BITS'(sat_next(MAX_CTR_BITS'(w_upd_ctr), local_correct,
                                             global_correct, CTR_BITS));

    // Write port is owned by the init sweep in INIT and by training in READY
    always_comb begin
        w_tbl_we    = 1'b0;
        w_tbl_widx  = update_hist;
        w_tbl_wdata = w_train_next;
        if (r_state == INIT) begin
            w_tbl_we    = 1'b1;
            w_tbl_widx  = r_init_ptr;
            w_tbl_wdata = CTR_BITS'(RESET_CTR);
        end else if (w_upd_en) begin
            w_tbl_we = 1'b1;
        end
    end

`ifdef CHOICE_BYPASS_EN
    assign w_lookup_ctr = (w_upd_en && (update_hist == r_ghr)) ? w_train_next : w_rd_ctr;
`else
    assign w_lookup_ctr = w_rd_ctr;
`endif

    choice_counter_table #(
        .HIST_BITS (HIST_BITS),
        .CTR_BITS  (CTR_BITS)
    ) u_table (
        .clock        (clock),
        .i_wr_en      (w_tbl_we),
        .i_wr_idx     (w_tbl_widx),
        .i_wr_data    (w_tbl_wdata),
        .i_rd_idx     (r_ghr),
        .o_rd_data_c  (w_rd_ctr),
        .i_upd_idx    (update_hist),
        .o_upd_data_c (w_upd_ctr)
    );

    // GHR shifts only on accepted updates; a same-cycle lookup sees the old value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_upd_en) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], update_taken};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pred_valid  <= 1'b0;
            r_prediction  <= 1'b0;
            r_lookup_hist <= '0;
            r_ready       <= 1'b0;
        end else begin
            r_pred_valid <= w_lookup_en;
            r_ready      <= (w_state_next == READY);
            if (w_lookup_en) begin
                r_prediction  <= w_lookup_ctr[CTR_BITS-1];
                r_lookup_hist <= r_ghr;
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign prediction  = r_prediction;
    assign lookup_hist = r_lookup_hist;
    assign ready       = r_ready;

endmodule

// File: tb/tb_choice_predictor_table.sv
// Directed self-checking bench for choice_predictor_table with HIST_BITS=4, CTR_BITS=2.
module tb_choice_predictor_table;

    localparam int unsigned HB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          lookup_valid = 1'b0;
    logic          pred_valid;
    logic          prediction;
    logic [HB-1:0] lookup_hist;
    logic          update_valid = 1'b0;
    logic [HB-1:0] update_hist = '0;
    logic          update_taken = 1'b0;
    logic          local_correct = 1'b0;
    logic          global_correct = 1'b0;
    logic          ready;

    int checks = 0;
    int errors = 0;

    choice_predictor_table #(.HIST_BITS(HB), .CTR_BITS(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .pred_valid     (pred_valid),
        .prediction     (prediction),
        .lookup_hist    (lookup_hist),
        .update_valid   (update_valid),
        .update_hist    (update_hist),
        .update_taken   (update_taken),
        .local_correct  (local_correct),
        .global_correct (global_correct),
        .ready          (ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_update(input logic [HB-1:0] idx, input logic tk, input logic lc, input logic gc);
        update_valid   = 1'b1;
        update_hist    = idx;
        update_taken   = tk;
        local_correct  = lc;
        global_correct = gc;
        step();
        update_valid   = 1'b0;
        local_correct  = 1'b0;
        global_correct = 1'b0;
    endtask

    task automatic set_ghr(input logic [HB-1:0] v);
        for (int i = HB - 1; i >= 0; i--) begin
            do_update('0, v[i], 1'b0, 1'b0);
        end
    endtask

    task automatic do_lookup(output logic pv, output logic pr, output logic [HB-1:0] hs);
        lookup_valid = 1'b1;
        step();
        lookup_valid = 1'b0;
        pv = pred_valid;
        pr = prediction;
        hs = lookup_hist;
    endtask

    // Counts cycles until ready rises, checking that no prediction is produced meanwhile
    task automatic sweep_and_count(input string tag, output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            step();
            cycles++;
            checks++;
            if (pred_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_pv_in_init: got %b want 0 at cycle %0d", tag, pred_valid, cycles);
            end
            if (ready === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 4;
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_pred_valid: got %b want 0", pred_valid); end
        if (prediction !== 1'b0) begin errors++; $display("FAIL rst_prediction: got %b want 0", prediction); end
        if (lookup_hist !== 4'd0) begin errors++; $display("FAIL rst_lookup_hist: got %0d want 0", lookup_hist); end
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    endtask

    task automatic test_init_sweep();
        int cyc;
        reset = 1'b0;
        lookup_valid = 1'b1;
        sweep_and_count("init", cyc);
        lookup_valid = 1'b0;
        checks++;
        if (cyc !== 16 || ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready_latency: got %0d cycles (ready=%b) want 16", cyc, ready);
        end
    endtask

    task automatic test_first_lookup();
        logic pv, pr;
        logic [HB-1:0] hs;
        do_lookup(pv, pr, hs);
        checks += 3;
        if (pv !== 1'b1) begin errors++; $display("FAIL first_pv: got %b want 1", pv); end
        if (hs !== 4'd0) begin errors++; $display("FAIL first_hist: got %0d want 0", hs); end
        if (pr !== 1'b0) begin errors++; $display("FAIL first_pred: got %b want 0", pr); end
        step();
        checks++;
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL idle_pv: got %b want 0", pred_valid); end
    endtask

    task automatic test_no_train();
        logic pv, pr;
        logic [HB-1:0] hs;
        // lookup and no-train update in the same cycle: lookup sees GHR before the shift
        lookup_valid = 1'b1;
        do_update(4'd0, 1'b1, 1'b1, 1'b1);
        lookup_valid = 1'b0;
        checks += 2;
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL coincide_pv: got %b want 1", pred_valid); end
        if (lookup_hist !== 4'd0) begin errors++; $display("FAIL coincide_hist: got %0d want 0", lookup_hist); end
        do_lookup(pv, pr, hs);
        checks++;
        if (hs !== 4'd1) begin errors++; $display("FAIL notrain_ghr_shift: got %0d want 1", hs); end
        // counter 6: 1 -> 2 (inc), -> 2 (equal flags), -> 1 (dec)
        do_update(4'd6, 1'b0, 1'b0, 1'b1);
        do_update(4'd6, 1'b0, 1'b1, 1'b1);
        set_ghr(4'd6);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b1) begin errors++; $display("FAIL notrain_hold_pred: got %b want 1", pr); end
        do_update(4'd6, 1'b0, 1'b1, 1'b0);
        set_ghr(4'd6);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b0) begin errors++; $display("FAIL notrain_after_dec_pred: got %b want 0", pr); end
    endtask

    task automatic test_training();
        logic pv, pr;
        logic [HB-1:0] hs;
        do_update(4'd5, 1'b1, 1'b0, 1'b1);
        set_ghr(4'd5);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b1) begin errors++; $display("FAIL train_inc1_pred: got %b want 1", pr); end
        do_update(4'd5, 1'b1, 1'b0, 1'b1);
        do_update(4'd5, 1'b1, 1'b0, 1'b1);
        set_ghr(4'd5);
        do_lookup(pv, pr, hs);
        checks += 2;
        if (hs !== 4'd5) begin errors++; $display("FAIL train_sat_hist: got %0d want 5", hs); end
        if (pr !== 1'b1) begin errors++; $display("FAIL train_sat_hi_pred: got %b want 1", pr); end
        // 3 -> 2 -> 1 after two local-correct updates
        do_update(4'd5, 1'b0, 1'b1, 1'b0);
        do_update(4'd5, 1'b0, 1'b1, 1'b0);
        set_ghr(4'd5);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b0) begin errors++; $display("FAIL train_dec_pred: got %b want 0", pr); end
        // counter 9: 1 -> 0 -> 0 (floor), then -> 1, -> 2
        do_update(4'd9, 1'b0, 1'b1, 1'b0);
        do_update(4'd9, 1'b0, 1'b1, 1'b0);
        do_update(4'd9, 1'b0, 1'b0, 1'b1);
        set_ghr(4'd9);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b0) begin errors++; $display("FAIL train_sat_lo_pred: got %b want 0", pr); end
        do_update(4'd9, 1'b0, 1'b0, 1'b1);
        set_ghr(4'd9);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b1) begin errors++; $display("FAIL train_lo_recover_pred: got %b want 1", pr); end
    endtask

    task automatic test_bypass();
        logic pv, pr, exp_pr;
        logic [HB-1:0] hs;
`ifdef CHOICE_BYPASS_EN
        exp_pr = 1'b1;
`else
        exp_pr = 1'b0;
`endif
        set_ghr(4'd10);
        lookup_valid = 1'b1;
        do_update(4'd10, 1'b0, 1'b0, 1'b1);
        lookup_valid = 1'b0;
        checks += 2;
        if (lookup_hist !== 4'd10) begin errors++; $display("FAIL bypass_hist: got %0d want 10", lookup_hist); end
        if (prediction !== exp_pr) begin errors++; $display("FAIL bypass_pred: got %b want %b", prediction, exp_pr); end
        set_ghr(4'd10);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b1) begin errors++; $display("FAIL bypass_written_pred: got %b want 1", pr); end
    endtask

    task automatic test_reset_mid_init();
        logic pv, pr;
        logic [HB-1:0] hs;
        int cyc;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        checks += 2;
        if (ready !== 1'b0) begin errors++; $display("FAIL midinit_ready: got %b want 0", ready); end
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL midinit_pv: got %b want 0", pred_valid); end
        reset = 1'b0;
        // updates held through INIT must be discarded
        update_valid = 1'b1; update_hist = 4'd9; update_taken = 1'b1;
        local_correct = 1'b0; global_correct = 1'b1;
        lookup_valid = 1'b1;
        sweep_and_count("restart", cyc);
        update_valid = 1'b0; global_correct = 1'b0; lookup_valid = 1'b0;
        checks++;
        if (cyc !== 16 || ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_ready_latency: got %0d cycles (ready=%b) want 16", cyc, ready);
        end
        do_lookup(pv, pr, hs);
        checks += 2;
        if (hs !== 4'd0) begin errors++; $display("FAIL restart_ghr: got %0d want 0", hs); end
        if (pr !== 1'b0) begin errors++; $display("FAIL restart_idx0_pred: got %b want 0", pr); end
        set_ghr(4'd9);
        do_lookup(pv, pr, hs);
        checks++;
        if (pr !== 1'b0) begin errors++; $display("FAIL restart_idx9_pred: got %b want 0", pr); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_first_lookup();
        test_no_train();
        test_training();
        test_bypass();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
